// File: rtl/bus_cycle_sync_pkg.sv
// Shared types and constants for the 6809 bus-cycle synchroniser.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bus_cycle_sync_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HIGH  = 2'd1,
        ISSUE = 2'd2
    } state_e;

    localparam int CNT_W       = 8;
    localparam int NUM_TGT_DEF = 4;

    // Chip-select / strobe bit positions.
    localparam int TGT_UART_DATA   = 0;
    localparam int TGT_UART_STATUS = 1;
    localparam int TGT_UART_CTRL   = 2;
    localparam int TGT_IOEXP       = 3;

endpackage

// File: rtl/bus_cycle_sync_delay.sv
// Parameterised WIDTH x STAGES flop chain with async active-low clear.
// Latency: STAGES clocks from d_i to q_o.
// Backpressure: none, free-running every clock.
module sync_delay_line #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // Shift the sample one stage further down the chain each clock.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/bus_cycle_sync.sv
// Synchronises 6809 E/RW/CS/address/data and emits one strobe per qualified bus cycle.
// Latency: strobe SYNC_STAGES+2 clocks after raw E falls.
// Backpressure: none; peripherals must accept a strobe in the clock it is presented.
module bus_cycle_sync
    import bus_cycle_sync_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_E_HIGH  = 8,
    parameter int NUM_TGT     = NUM_TGT_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_E,
    input  logic               i_RW,
    input  logic [15:0]        i_ADDRESS_BUS,
    input  logic [7:0]         i_DATA,
    input  logic [NUM_TGT-1:0] i_cs,
    output logic [NUM_TGT-1:0] o_rd_strobe,
    output logic [NUM_TGT-1:0] o_wr_strobe,
    output logic [15:0]        o_addr,
    output logic [7:0]         o_wdata,
    output logic               o_cycle_active,
    output logic               o_bus_err
);

    localparam int CTRL_W = NUM_TGT + 2;
    localparam int BUS_W  = 16 + 8;

    // Synchronised control and equally delayed address/data.
    logic [CTRL_W-1:0]  ctrl_sync;
    logic [BUS_W-1:0]   bus_dly;
    logic               e_sync;
    logic               rw_sync;
    logic [NUM_TGT-1:0] cs_sync;
    logic [15:0]        addr_dly;
    logic [7:0]         data_dly;

    sync_delay_line #(
        .WIDTH  (CTRL_W),
        .STAGES (SYNC_STAGES)
    ) u_ctrl_sync (
        .clk_i   (clk),
        .rst_n_i (reset),
        .d_i     ({i_E, i_RW, i_cs}),
        .q_o     (ctrl_sync)
    );

    sync_delay_line #(
        .WIDTH  (BUS_W),
        .STAGES (SYNC_STAGES)
    ) u_bus_dly (
        .clk_i   (clk),
        .rst_n_i (reset),
        .d_i     ({i_ADDRESS_BUS, i_DATA}),
        .q_o     (bus_dly)
    );

    assign e_sync   = ctrl_sync[CTRL_W-1];
    assign rw_sync  = ctrl_sync[CTRL_W-2];
    assign cs_sync  = ctrl_sync[NUM_TGT-1:0];
    assign addr_dly = bus_dly[BUS_W-1:8];
    assign data_dly = bus_dly[7:0];

    // The synchroniser holds reset zeros for SYNC_STAGES clocks; prime_q marks
    // when e_sync carries a real sample. arm_q only sets once a real low E is
    // seen, so an E already high at reset release never looks like a rise.
    logic [SYNC_STAGES-1:0] prime_q;
    logic                   arm_q;
    logic                   e_d_q;
    logic                   primed;
    logic                   rise;
    logic                   fall;

    assign primed = prime_q[SYNC_STAGES-1];
    assign rise   = e_sync & ~e_d_q & arm_q;
    assign fall   = ~e_sync & e_d_q;

    // Edge-detect history and post-reset arming.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prime_q <= '0;
            arm_q   <= 1'b0;
            e_d_q   <= 1'b0;
        end else begin
            prime_q <= {prime_q[SYNC_STAGES-2:0], 1'b1};
            arm_q   <= arm_q | (primed & ~e_sync);
            e_d_q   <= e_sync;
        end
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        addr_h_q, addr_h_d;
    logic [7:0]         data_h_q, data_h_d;
    logic               rw_h_q, rw_h_d;
    logic [NUM_TGT-1:0] cs_h_q, cs_h_d;
    logic [NUM_TGT-1:0] rd_q, rd_d;
    logic [NUM_TGT-1:0] wr_q, wr_d;
    logic               err_q, err_d;
    logic [15:0]        addr_q, addr_d;
    logic [7:0]         wdata_q, wdata_d;
    logic               cs_onehot;

    assign cs_onehot = (cs_h_q != '0) && ((cs_h_q & (cs_h_q - NUM_TGT'(1))) == '0);

    // Next-state, hold-register and strobe decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_h_d = addr_h_q;
        data_h_d = data_h_q;
        rw_h_d   = rw_h_q;
        cs_h_d   = cs_h_q;
        rd_d     = '0;
        wr_d     = '0;
        err_d    = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;

        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d  = HIGH;
                    cnt_d    = CNT_W'(1);
                    addr_h_d = addr_dly;
                    data_h_d = data_dly;
                    rw_h_d   = rw_sync;
                    cs_h_d   = cs_sync;
                end
            end
            HIGH: begin
                if (e_sync) begin
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    addr_h_d = addr_dly;
                    data_h_d = data_dly;
                    rw_h_d   = rw_sync;
                    cs_h_d   = cs_sync;
                end else if (fall) begin
                    if (cnt_q >= CNT_W'(MIN_E_HIGH)) begin
                        state_d = ISSUE;
                    end else begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            ISSUE: begin
                state_d = IDLE;
                if (cs_onehot) begin
                    addr_d = addr_h_q;
                    if (rw_h_q) begin
                        rd_d = cs_h_q;
                    end else begin
                        wr_d    = cs_h_q;
                        wdata_d = data_h_q;
                    end
                end else if (cs_h_q != '0) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter, hold and registered-output update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_h_q <= '0;
            data_h_q <= '0;
            rw_h_q   <= 1'b0;
            cs_h_q   <= '0;
            rd_q     <= '0;
            wr_q     <= '0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_h_q <= addr_h_d;
            data_h_q <= data_h_d;
            rw_h_q   <= rw_h_d;
            cs_h_q   <= cs_h_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign o_rd_strobe    = rd_q;
    assign o_wr_strobe    = wr_q;
    assign o_addr         = addr_q;
    assign o_wdata        = wdata_q;
    assign o_bus_err      = err_q;
    assign o_cycle_active = (state_q == HIGH);

endmodule

// File: tb/tb_bus_cycle_sync.sv
// Directed bench for bus_cycle_sync: write/read/glitch/decode/reset/data-hold cycles.
// Latency: checks strobe lands SYNC_STAGES+2 clocks after raw E falls.
// Backpressure: n/a.
module tb_bus_cycle_sync;

    localparam int S  = 2;
    localparam int NT = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          i_E = 1'b0;
    logic          i_RW = 1'b0;
    logic [15:0]   i_ADDRESS_BUS = '0;
    logic [7:0]    i_DATA = '0;
    logic [NT-1:0] i_cs = '0;
    logic [NT-1:0] o_rd_strobe;
    logic [NT-1:0] o_wr_strobe;
    logic [15:0]   o_addr;
    logic [7:0]    o_wdata;
    logic          o_cycle_active;
    logic          o_bus_err;

    int vectors = 0;
    int miscompares = 0;

    int cyc = 0;
    int rd_n = 0;
    int wr_n = 0;
    int err_n = 0;
    int stb_cyc = -1;
    logic [NT-1:0] rd_last = '0;
    logic [NT-1:0] wr_last = '0;

    bus_cycle_sync #(
        .SYNC_STAGES (S),
        .MIN_E_HIGH  (8),
        .NUM_TGT     (NT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_E            (i_E),
        .i_RW           (i_RW),
        .i_ADDRESS_BUS  (i_ADDRESS_BUS),
        .i_DATA         (i_DATA),
        .i_cs           (i_cs),
        .o_rd_strobe    (o_rd_strobe),
        .o_wr_strobe    (o_wr_strobe),
        .o_addr         (o_addr),
        .o_wdata        (o_wdata),
        .o_cycle_active (o_cycle_active),
        .o_bus_err      (o_bus_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse counters; a strobe lasting two clocks counts twice.
    always @(negedge clk) begin
        if (|o_rd_strobe) begin
            rd_n    <= rd_n + 1;
            rd_last <= o_rd_strobe;
            stb_cyc <= cyc;
        end
        if (|o_wr_strobe) begin
            wr_n    <= wr_n + 1;
            wr_last <= o_wr_strobe;
            stb_cyc <= cyc;
        end
        if (o_bus_err) err_n <= err_n + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One bus cycle: E high for 'high' clocks, then low for 12 clocks.
    // Data switches to d_after one clock after E falls.
    task automatic run_cycle(input int high, input logic rw, input logic [15:0] a,
                             input logic [7:0] d, input logic [7:0] d_after,
                             input logic [NT-1:0] cs, output int fall_cyc,
                             output logic act_mid);
        @(posedge clk); #1;
        i_RW = rw; i_ADDRESS_BUS = a; i_DATA = d; i_cs = cs; i_E = 1'b1;
        act_mid = 1'b0;
        for (int k = 0; k < high; k++) begin
            @(posedge clk);
            if (k == S + 2) begin
                @(negedge clk);
                act_mid = o_cycle_active;
            end
        end
        #1;
        i_E = 1'b0;
        fall_cyc = cyc;
        @(posedge clk); #1;
        i_DATA = d_after;
        repeat (12) @(posedge clk);
    endtask

    int   r0, w0, e0, fc;
    logic act;

    initial begin
        // Reset state.
        @(negedge clk);
        check("rst_rd", o_rd_strobe, 4'b0000);
        check("rst_wr", o_wr_strobe, 4'b0000);
        check("rst_addr", o_addr, 16'h0000);
        check("rst_wdata", o_wdata, 8'h00);
        check("rst_active", o_cycle_active, 1'b0);
        check("rst_err", o_bus_err, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (5) @(posedge clk);

        // Write cycle.
        r0 = rd_n; w0 = wr_n; e0 = err_n;
        run_cycle(44, 1'b0, 16'hA001, 8'h5A, 8'h5A, 4'b0001, fc, act);
        check("wr_active_mid", act, 1'b1);
        check("wr_count", wr_n - w0, 1);
        check("wr_bits", wr_last, 4'b0001);
        check("wr_latency", stb_cyc - fc, S + 2);
        check("wr_no_rd", rd_n - r0, 0);
        check("wr_no_err", err_n - e0, 0);
        check("wr_addr", o_addr, 16'hA001);
        check("wr_wdata", o_wdata, 8'h5A);

        // Read cycle.
        r0 = rd_n; w0 = wr_n; e0 = err_n;
        run_cycle(44, 1'b1, 16'hA000, 8'hFF, 8'hFF, 4'b0010, fc, act);
        check("rd_count", rd_n - r0, 1);
        check("rd_bits", rd_last, 4'b0010);
        check("rd_latency", stb_cyc - fc, S + 2);
        check("rd_no_wr", wr_n - w0, 0);
        check("rd_wdata_kept", o_wdata, 8'h5A);
        check("rd_addr", o_addr, 16'hA000);

        // Glitch: 3 clocks high.
        r0 = rd_n; w0 = wr_n; e0 = err_n;
        run_cycle(3, 1'b0, 16'hA001, 8'h11, 8'h11, 4'b0001, fc, act);
        check("gl_no_wr", wr_n - w0, 0);
        check("gl_no_rd", rd_n - r0, 0);
        check("gl_err", err_n - e0, 1);
        @(negedge clk);
        check("gl_idle", o_cycle_active, 1'b0);
        check("gl_addr_kept", o_addr, 16'hA000);

        // Normal cycle after glitch.
        w0 = wr_n; e0 = err_n;
        run_cycle(44, 1'b0, 16'hA002, 8'h33, 8'h33, 4'b0100, fc, act);
        check("pg_wr_count", wr_n - w0, 1);
        check("pg_wr_bits", wr_last, 4'b0100);
        check("pg_wdata", o_wdata, 8'h33);
        check("pg_no_err", err_n - e0, 0);

        // Qualification boundary: 7 clocks rejected, 8 accepted.
        w0 = wr_n; e0 = err_n;
        run_cycle(7, 1'b0, 16'hA004, 8'h44, 8'h44, 4'b0001, fc, act);
        check("min7_no_wr", wr_n - w0, 0);
        check("min7_err", err_n - e0, 1);
        w0 = wr_n; e0 = err_n;
        run_cycle(8, 1'b0, 16'hA005, 8'h55, 8'h55, 4'b0001, fc, act);
        check("min8_wr", wr_n - w0, 1);
        check("min8_no_err", err_n - e0, 0);
        check("min8_wdata", o_wdata, 8'h55);

        // Decode: no select.
        r0 = rd_n; w0 = wr_n; e0 = err_n;
        run_cycle(44, 1'b0, 16'h1234, 8'h99, 8'h99, 4'b0000, fc, act);
        check("cs0_no_wr", wr_n - w0, 0);
        check("cs0_no_err", err_n - e0, 0);
        check("cs0_addr_kept", o_addr, 16'hA005);

        // Decode: two selects.
        r0 = rd_n; w0 = wr_n; e0 = err_n;
        run_cycle(44, 1'b1, 16'h4321, 8'h00, 8'h00, 4'b0011, fc, act);
        check("cs3_no_rd", rd_n - r0, 0);
        check("cs3_err", err_n - e0, 1);
        check("cs3_addr_kept", o_addr, 16'hA005);

        // Data changes one clock after E falls; captured value must be the old one.
        w0 = wr_n;
        run_cycle(44, 1'b0, 16'hA003, 8'h5A, 8'h00, 4'b1000, fc, act);
        check("dh_wr_bits", wr_last, 4'b1000);
        check("dh_count", wr_n - w0, 1);
        check("dh_wdata", o_wdata, 8'h5A);
        check("dh_addr", o_addr, 16'hA003);

        // Reset mid-cycle, released with E still high.
        @(posedge clk); #1;
        i_RW = 1'b0; i_ADDRESS_BUS = 16'hA00F; i_DATA = 8'h77; i_cs = 4'b0001; i_E = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("mr_active", o_cycle_active, 1'b0);
        check("mr_addr", o_addr, 16'h0000);
        check("mr_wdata", o_wdata, 8'h00);
        r0 = rd_n; w0 = wr_n; e0 = err_n;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("mr_stay_idle", o_cycle_active, 1'b0);
        repeat (18) @(posedge clk);
        #1;
        i_E = 1'b0;
        repeat (12) @(posedge clk);
        check("mr_no_wr", wr_n - w0, 0);
        check("mr_no_rd", rd_n - r0, 0);
        check("mr_no_err", err_n - e0, 0);

        // Next full cycle after reset strobes once.
        w0 = wr_n; e0 = err_n;
        run_cycle(44, 1'b0, 16'hA010, 8'hC3, 8'hC3, 4'b0100, fc, act);
        check("ar_wr_count", wr_n - w0, 1);
        check("ar_wr_bits", wr_last, 4'b0100);
        check("ar_wdata", o_wdata, 8'hC3);
        check("ar_addr", o_addr, 16'hA010);
        check("ar_no_err", err_n - e0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
